// File: rtl/ctrl_pkt_pkg.sv
// Shared definitions for the control-packet configuration path:
// header field offsets, resource-type encoding, FSM state encoding
// and a saturating counter helper.
package ctrl_pkt_pkg;

  // Bit offsets of the control header fields inside beat 1.
  localparam int MOD_ID_LSB = 112;
  localparam int MAGIC_LSB  = 120;
  localparam int BASE_LSB   = 128;
  localparam int CNT_LSB    = 136;

  // UDP destination port that marks a control packet.
  localparam logic [15:0] CONTROL_PORT = 16'hF2F1;

  // Header magic byte expected by default.
  localparam logic [7:0] DEFAULT_CTRL_MAGIC = 8'hA5;

  // Resource type carried in mod_id[2:0]; mod_id[7:3] selects the stage.
  typedef enum logic [2:0] {
    RES_PARSER      = 3'd0,
    RES_KEY_EXTRACT = 3'd1,
    RES_KEY_MASK    = 3'd2,
    RES_LOOKUP_CAM  = 3'd3,
    RES_LOOKUP_RAM  = 3'd4,
    RES_SEG_TABLE   = 3'd5,
    RES_RSVD6       = 3'd6,
    RES_RSVD7       = 3'd7
  } res_type_e;

  // Decoder FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DISCARD = 2'd3
  } cfg_state_e;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fallthrough FIFO: dout always shows the head entry
// while empty is low. A write while full is accepted only when a read
// happens in the same cycle, since that read frees the slot.
module fallthrough_small_fifo #(
  parameter int WIDTH          = 272,
  parameter int MAX_DEPTH_BITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS:0] FULL_LVL = {1'b1, {MAX_DEPTH_BITS{1'b0}}};

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [MAX_DEPTH_BITS:0]   count_q;
  logic                      do_wr, do_rd;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_LVL);
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);
  assign dout  = mem[rd_ptr_q];

  // Storage array; contents are don't-care while the slot is not occupied.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_cfg_decoder.sv
// Control-packet decoder: registers the control stream, parses the
// header in beat 1 and turns each payload beat into one table/register
// write command, buffered in a fallthrough FIFO so the filter is never
// stalled. Full-FIFO losses, bad magic and short packets are counted.
module ctrl_cfg_decoder
  import ctrl_pkt_pkg::*;
#(
  parameter int          C_S_AXIS_DATA_WIDTH  = 256,
  parameter int          C_S_AXIS_TUSER_WIDTH = 128,
  parameter logic [7:0]  CTRL_MAGIC           = DEFAULT_CTRL_MAGIC,
  parameter int          FIFO_DEPTH_BITS      = 4
) (
  input  logic                              clk,
  input  logic                              areset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    ctrl_s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  ctrl_s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   ctrl_s_axis_tuser,
  input  logic                              ctrl_s_axis_tvalid,
  input  logic                              ctrl_s_axis_tlast,
  output logic                              cfg_wr_valid,
  input  logic                              cfg_wr_ready,
  output logic [7:0]                        cfg_wr_mod_id,
  output logic [7:0]                        cfg_wr_addr,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    cfg_wr_data,
  output logic [15:0]                       stat_drop_cnt,
  output logic [15:0]                       stat_bad_hdr_cnt,
  output logic [15:0]                       stat_short_cnt,
  output cfg_state_e                        dbg_state_o
);

  // Handshake: a command transfers in every cycle where cfg_wr_valid and
  // cfg_wr_ready are both high; valid stays high and the command stable
  // until that happens. The input stream has no ready: every beat with
  // tvalid high is taken, and what cannot be stored is dropped and counted.

  localparam int EW = 8 + 8 + C_S_AXIS_DATA_WIDTH;

  // tkeep/tuser carry nothing the decoder needs.
  logic unused_ok;
  assign unused_ok = ^{ctrl_s_axis_tkeep, ctrl_s_axis_tuser};

  // Reset asserts asynchronously and releases on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst;
  always_ff @(posedge clk or posedge areset) begin
    if (areset) rst_sync_q <= 2'b11;
    else        rst_sync_q <= {rst_sync_q[0], 1'b0};
  end
  assign rst = rst_sync_q[1];

  // Beat register: all parsing works on this registered copy.
  logic                           beat_vld_q, beat_last_q;
  logic [C_S_AXIS_DATA_WIDTH-1:0] beat_data_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_vld_q  <= 1'b0;
      beat_last_q <= 1'b0;
      beat_data_q <= '0;
    end else begin
      beat_vld_q <= ctrl_s_axis_tvalid;
      if (ctrl_s_axis_tvalid) begin
        beat_last_q <= ctrl_s_axis_tlast;
        beat_data_q <= ctrl_s_axis_tdata;
      end
    end
  end

  logic [7:0] hdr_mod, hdr_magic, hdr_base, hdr_cnt;
  assign hdr_mod   = beat_data_q[MOD_ID_LSB +: 8];
  assign hdr_magic = beat_data_q[MAGIC_LSB  +: 8];
  assign hdr_base  = beat_data_q[BASE_LSB   +: 8];
  assign hdr_cnt   = beat_data_q[CNT_LSB    +: 8];

  cfg_state_e state_q, state_d;
  logic [7:0] mod_q, mod_d, base_q, base_d, cnt_q, cnt_d, k_q, k_d;
  logic       push, bad_inc, short_inc;
  logic [8:0] k_next;

  assign k_next = {1'b0, k_q} + 9'd1;

  // FSM state and latched header fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mod_q   <= '0;
      base_q  <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      mod_q   <= mod_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
    end
  end

  // Next state, entry push and header/short error flags; idle beats hold everything.
  always_comb begin
    state_d   = state_q;
    mod_d     = mod_q;
    base_d    = base_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    push      = 1'b0;
    bad_inc   = 1'b0;
    short_inc = 1'b0;
    if (beat_vld_q) begin
      case (state_q)
        ST_IDLE: begin
          if (!beat_last_q) state_d = ST_HDR;
        end
        ST_HDR: begin
          mod_d  = hdr_mod;
          base_d = hdr_base;
          cnt_d  = hdr_cnt;
          k_d    = '0;
          if (hdr_magic != CTRL_MAGIC) begin
            bad_inc = 1'b1;
            state_d = beat_last_q ? ST_IDLE : ST_DISCARD;
          end else if (beat_last_q) begin
            short_inc = (hdr_cnt != 8'd0);
            state_d   = ST_IDLE;
          end else if (hdr_cnt == 8'd0) begin
            state_d = ST_DISCARD;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          push = 1'b1;
          k_d  = k_next[7:0];
          if (beat_last_q) begin
            short_inc = (k_next < {1'b0, cnt_q});
            state_d   = ST_IDLE;
          end else if (k_next == {1'b0, cnt_q}) begin
            state_d = ST_DISCARD;
          end
        end
        default: begin
          if (beat_last_q) state_d = ST_IDLE;
        end
      endcase
    end
  end

  logic          fifo_full, fifo_empty, pop, push_ok, drop_inc;
  logic [EW-1:0] fifo_din, fifo_dout;

  assign fifo_din = {mod_q, base_q + k_q, beat_data_q};
  assign pop      = ~fifo_empty & cfg_wr_ready;
  assign push_ok  = push & (~fifo_full | pop);
  assign drop_inc = push & ~push_ok;

  fallthrough_small_fifo #(
    .WIDTH          (EW),
    .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_wr_fifo (
    .clk   (clk),
    .reset (rst),
    .din   (fifo_din),
    .wr_en (push_ok),
    .rd_en (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Head entry is forced to zero while the FIFO is empty.
  assign cfg_wr_valid = ~fifo_empty;
  assign {cfg_wr_mod_id, cfg_wr_addr, cfg_wr_data} = fifo_empty ? '0 : fifo_dout;

  // Saturating statistics; each counter steps independently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_drop_cnt    <= '0;
      stat_bad_hdr_cnt <= '0;
      stat_short_cnt   <= '0;
    end else begin
      if (drop_inc)  stat_drop_cnt    <= sat_inc(stat_drop_cnt);
      if (bad_inc)   stat_bad_hdr_cnt <= sat_inc(stat_bad_hdr_cnt);
      if (short_inc) stat_short_cnt   <= sat_inc(stat_short_cnt);
    end
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ctrl_cfg_decoder.sv
// Testbench for ctrl_cfg_decoder: packet-level reference model feeding an
// expected-command queue, a monitor that scores every popped command,
// and one task per scenario.
module tb_ctrl_cfg_decoder;
  import ctrl_pkt_pkg::*;

  localparam int         DW    = 256;
  localparam int         UW    = 128;
  localparam int         DEPTH = 16;
  localparam logic [7:0] MAGIC = 8'hA5;

  logic          clk = 1'b0;
  logic          areset;
  logic [DW-1:0] tdata;
  logic [DW/8-1:0] tkeep;
  logic [UW-1:0] tuser;
  logic          tvalid, tlast;
  logic          cfg_wr_valid, cfg_wr_ready;
  logic [7:0]    cfg_wr_mod_id, cfg_wr_addr;
  logic [DW-1:0] cfg_wr_data;
  logic [15:0]   stat_drop_cnt, stat_bad_hdr_cnt, stat_short_cnt;
  cfg_state_e    dbg_state;

  ctrl_cfg_decoder dut (
    .clk                (clk),
    .areset             (areset),
    .ctrl_s_axis_tdata  (tdata),
    .ctrl_s_axis_tkeep  (tkeep),
    .ctrl_s_axis_tuser  (tuser),
    .ctrl_s_axis_tvalid (tvalid),
    .ctrl_s_axis_tlast  (tlast),
    .cfg_wr_valid       (cfg_wr_valid),
    .cfg_wr_ready       (cfg_wr_ready),
    .cfg_wr_mod_id      (cfg_wr_mod_id),
    .cfg_wr_addr        (cfg_wr_addr),
    .cfg_wr_data        (cfg_wr_data),
    .stat_drop_cnt      (stat_drop_cnt),
    .stat_bad_hdr_cnt   (stat_bad_hdr_cnt),
    .stat_short_cnt     (stat_short_cnt),
    .dbg_state_o        (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time budget, required completion");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [8+8+DW-1:0] exp_q[$];
  int exp_drop  = 0;
  int exp_bad   = 0;
  int exp_short = 0;
  bit model_ready = 1'b1;
  bit arm_first   = 1'b0;
  int first_valid_cyc = -1;
  int beat2_cyc = 0;
  logic [DW-1:0] pkt [64];

  // Monitor: every transferred command must be the next expected one.
  always @(negedge clk) begin
    if (arm_first && cfg_wr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (cfg_wr_valid && cfg_wr_ready && !areset) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL cmd_unexpected: got mod=%h addr=%h, required no command", cfg_wr_mod_id, cfg_wr_addr);
      end else begin
        logic [8+8+DW-1:0] e;
        e = exp_q.pop_front();
        if ({cfg_wr_mod_id, cfg_wr_addr, cfg_wr_data} !== e) begin
          n_fail++;
          $display("FAIL cmd_content: got mod=%h addr=%h data=%h, required mod=%h addr=%h data=%h",
                   cfg_wr_mod_id, cfg_wr_addr, cfg_wr_data, e[8+8+DW-1 -: 8], e[DW+7 -: 8], e[DW-1:0]);
        end
      end
    end
  end

  // Packet-level reference: what a whole packet should produce.
  task automatic model_packet(input int nbeats);
    logic [7:0] m, mg, b, n;
    int payload, ent;
    if (nbeats < 2) return;
    m  = pkt[1][119:112];
    mg = pkt[1][127:120];
    b  = pkt[1][135:128];
    n  = pkt[1][143:136];
    if (mg != MAGIC) begin
      exp_bad++;
    end else if (nbeats == 2) begin
      if (n != 0) exp_short++;
    end else if (n != 0) begin
      payload = nbeats - 2;
      ent = (payload < int'(n)) ? payload : int'(n);
      for (int i = 0; i < ent; i++) begin
        logic [7:0] a;
        a = b + 8'(i);
        if (!model_ready && exp_q.size() >= DEPTH) exp_drop++;
        else exp_q.push_back({m, a, pkt[2+i]});
      end
      if (payload < int'(n)) exp_short++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_cycle();
    @(posedge clk); #1;
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic build_packet(input logic [7:0] m, input logic [7:0] mg,
                              input logic [7:0] b, input logic [7:0] n, input int nbeats);
    for (int i = 0; i < nbeats; i++)
      for (int w = 0; w < DW/32; w++) pkt[i][w*32 +: 32] = $urandom();
    if (nbeats > 1) begin
      pkt[1][119:112] = m;
      pkt[1][127:120] = mg;
      pkt[1][135:128] = b;
      pkt[1][143:136] = n;
    end
  endtask

  task automatic drive_beats(input int first, input int last_idx, input bit with_last, input int max_gap);
    for (int i = first; i <= last_idx; i++) begin
      int g;
      g = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      for (int j = 0; j < g; j++) idle_cycle();
      @(posedge clk); #1;
      tvalid = 1'b1;
      tdata  = pkt[i];
      tkeep  = '1;
      tuser  = {$urandom(), $urandom(), $urandom(), $urandom()};
      tlast  = with_last && (i == last_idx);
      if (i == 2) beat2_cyc = cyc;
    end
    idle_cycle();
  endtask

  task automatic send_packet(input logic [7:0] m, input logic [7:0] mg, input logic [7:0] b,
                             input logic [7:0] n, input int nbeats, input int max_gap);
    build_packet(m, mg, b, n, nbeats);
    model_packet(nbeats);
    drive_beats(0, nbeats - 1, 1'b1, max_gap);
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    areset = 1'b1; tvalid = 1'b0; tlast = 1'b0; tdata = '0; tkeep = '0; tuser = '0;
    cfg_wr_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 areset = 1'b0;
    settle(4);
    n_tests++;
    if (cfg_wr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", cfg_wr_valid); end
    n_tests++;
    if ({cfg_wr_mod_id, cfg_wr_addr, cfg_wr_data} !== '0) begin n_fail++; $display("FAIL reset_cmd: got mod=%h addr=%h, required 0", cfg_wr_mod_id, cfg_wr_addr); end
    n_tests++;
    if ({stat_drop_cnt, stat_bad_hdr_cnt, stat_short_cnt} !== '0) begin n_fail++; $display("FAIL reset_counters: got %h/%h/%h, required 0", stat_drop_cnt, stat_bad_hdr_cnt, stat_short_cnt); end
    n_tests++;
    if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d, required IDLE", dbg_state); end
  endtask

  task automatic test_basic();
    model_ready = 1'b1; cfg_wr_ready = 1'b1;
    first_valid_cyc = -1; arm_first = 1'b1;
    send_packet(8'h09, MAGIC, 8'h10, 8'd2, 4, 0);
    settle(6);
    arm_first = 1'b0;
    n_tests++;
    if (first_valid_cyc - beat2_cyc !== 2) begin n_fail++; $display("FAIL basic_latency: got %0d cycles, required 2", first_valid_cyc - beat2_cyc); end
    n_tests++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL basic_drain: got %0d missing commands, required 0", exp_q.size()); end
    n_tests++;
    if ({stat_drop_cnt, stat_bad_hdr_cnt, stat_short_cnt} !== '0) begin n_fail++; $display("FAIL basic_counters: got %h/%h/%h, required 0", stat_drop_cnt, stat_bad_hdr_cnt, stat_short_cnt); end
  endtask

  task automatic test_bad_magic();
    send_packet(8'h11, 8'h5A, 8'h20, 8'd2, 5, 0);
    send_packet(8'h12, MAGIC, 8'h30, 8'd1, 3, 1);
    settle(6);
    n_tests++;
    if (stat_bad_hdr_cnt !== 16'(exp_bad) || exp_bad != 1) begin n_fail++; $display("FAIL bad_magic_cnt: got %0d, required 1 (model %0d)", stat_bad_hdr_cnt, exp_bad); end
    n_tests++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL bad_magic_drain: got %0d missing commands, required 0", exp_q.size()); end
  endtask

  task automatic test_short();
    send_packet(8'h1B, MAGIC, 8'h40, 8'd4, 4, 0);
    settle(6);
    n_tests++;
    if (stat_short_cnt !== 16'(exp_short)) begin n_fail++; $display("FAIL short_cnt: got %0d, required %0d", stat_short_cnt, exp_short); end
    n_tests++;
    if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL short_state: got %0d, required IDLE", dbg_state); end
    n_tests++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL short_drain: got %0d missing commands, required 0", exp_q.size()); end
  endtask

  task automatic test_overflow();
    @(posedge clk); #1;
    cfg_wr_ready = 1'b0; model_ready = 1'b0;
    send_packet(8'h2C, MAGIC, 8'h50, 8'd20, 22, 0);
    settle(4);
    n_tests++;
    if (stat_drop_cnt !== 16'(exp_drop) || exp_drop != 4) begin n_fail++; $display("FAIL ovf_drop_cnt: got %0d, required 4 (model %0d)", stat_drop_cnt, exp_drop); end
    n_tests++;
    if (cfg_wr_valid !== 1'b1 || cfg_wr_addr !== 8'h50) begin n_fail++; $display("FAIL ovf_head: got valid=%b addr=%h, required 1/50", cfg_wr_valid, cfg_wr_addr); end
    @(posedge clk); #1;
    cfg_wr_ready = 1'b1; model_ready = 1'b1;
    settle(24);
    n_tests++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL ovf_drain: got %0d missing commands, required 0", exp_q.size()); end
    n_tests++;
    if (cfg_wr_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got valid=%b, required 0", cfg_wr_valid); end
  endtask

  task automatic test_wrap();
    send_packet(8'h33, MAGIC, 8'hFE, 8'd3, 7, 0);
    settle(6);
    n_tests++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL wrap_drain: got %0d missing commands, required 0", exp_q.size()); end
    n_tests++;
    if (stat_drop_cnt !== 16'(exp_drop) || stat_bad_hdr_cnt !== 16'(exp_bad) || stat_short_cnt !== 16'(exp_short)) begin
      n_fail++; $display("FAIL wrap_counters: got %0d/%0d/%0d, required %0d/%0d/%0d", stat_drop_cnt, stat_bad_hdr_cnt, stat_short_cnt, exp_drop, exp_bad, exp_short);
    end
  endtask

  task automatic test_random();
    for (int p = 0; p < 25; p++) begin
      logic [7:0] mg;
      mg = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : MAGIC;
      send_packet(8'($urandom()), mg, 8'($urandom()), 8'($urandom_range(0, 6)), $urandom_range(1, 8), 2);
    end
    settle(6);
    n_tests++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL random_drain: got %0d missing commands, required 0", exp_q.size()); end
    n_tests++;
    if (stat_drop_cnt !== 16'(exp_drop) || stat_bad_hdr_cnt !== 16'(exp_bad) || stat_short_cnt !== 16'(exp_short)) begin
      n_fail++; $display("FAIL random_counters: got %0d/%0d/%0d, required %0d/%0d/%0d", stat_drop_cnt, stat_bad_hdr_cnt, stat_short_cnt, exp_drop, exp_bad, exp_short);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    cfg_wr_ready = 1'b0; model_ready = 1'b0;
    build_packet(8'h44, MAGIC, 8'h60, 8'd10, 8);
    drive_beats(0, 4, 1'b0, 0);
    settle(2);
    n_tests++;
    if (cfg_wr_valid !== 1'b1 || dbg_state !== ST_PAYLOAD) begin n_fail++; $display("FAIL midrst_pre: got valid=%b state=%0d, required 1/PAYLOAD", cfg_wr_valid, dbg_state); end
    #1 areset = 1'b1;
    #1;
    n_tests++;
    if (cfg_wr_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b, required 0", cfg_wr_valid); end
    n_tests++;
    if ({stat_drop_cnt, stat_bad_hdr_cnt, stat_short_cnt} !== '0) begin n_fail++; $display("FAIL midrst_counters: got %h/%h/%h, required 0", stat_drop_cnt, stat_bad_hdr_cnt, stat_short_cnt); end
    exp_q.delete(); exp_drop = 0; exp_bad = 0; exp_short = 0;
    repeat (2) @(posedge clk);
    #1 areset = 1'b0;
    repeat (3) @(posedge clk);
    #1 cfg_wr_ready = 1'b1; model_ready = 1'b1;
    send_packet(8'h45, 8'h00, 8'h61, 8'd3, 2, 0);
    send_packet(8'h46, MAGIC, 8'h70, 8'd2, 4, 0);
    settle(6);
    n_tests++;
    if (stat_bad_hdr_cnt !== 16'(exp_bad) || exp_bad != 1) begin n_fail++; $display("FAIL midrst_bad: got %0d, required 1", stat_bad_hdr_cnt); end
    n_tests++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL midrst_drain: got %0d missing commands, required 0", exp_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_bad_magic();
    test_short();
    test_overflow();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
